// File: rtl/spa_trigger_ctrl.sv
// spa_trigger_ctrl: sequences one side-channel capture. It starts the RO
// sampler, waits a programmable pre-trigger delay, fires the RSA core one or
// more times with a fixed gap, then waits for the DMA write-back. All outputs
// are registered from the next-state decode, so the sensor-to-victim offset
// is cycle exact and no input reaches an output combinationally.
module spa_trigger_ctrl #(
  parameter int CNT_WIDTH = 65,
  parameter int RUN_WIDTH = 16,
  parameter int TIMEOUT   = 2**24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] trigger_delay,
  input  logic [RUN_WIDTH-1:0] num_runs,
  input  logic [RUN_WIDTH-1:0] run_gap,
  input  logic                 rsa_ready,
  input  logic                 capture_done,
  output logic                 ro_go,
  output logic                 rsa_go,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [RUN_WIDTH-1:0] run_count
);

  // Watchdog only has to reach TIMEOUT-1; one spare value keeps TIMEOUT=1 legal.
  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, ARM, DELAY, FIRE, WAIT_LOW, WAIT_HIGH, GAP, WAIT_CAP, DONE
  } state_t;

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] dly_q, dly_d, cnt, cnt_d;
  logic [RUN_WIDTH-1:0] runs_q, runs_d, gap_q, gap_d, gcnt, gcnt_d, rc_d;
  logic [WD_W-1:0]      wdog, wdog_d;
  logic                 done_d, terr_d, idle;
  logic [RUN_WIDTH:0]   rc_inc;

  // One extra bit so the last-run compare cannot wrap at the top of the range.
  assign rc_inc = {1'b0, run_count} + 1'b1;
  assign idle   = (state == IDLE) || (state == DONE);

  // Next-state and next-value decode; abort from any busy state wins over all.
  always_comb begin
    state_d = state;
    dly_d   = dly_q;
    runs_d  = runs_q;
    gap_d   = gap_q;
    cnt_d   = cnt;
    gcnt_d  = gcnt;
    wdog_d  = wdog;
    done_d  = done;
    terr_d  = timeout_err;
    rc_d    = run_count;
    if (!idle && abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (go) begin
          dly_d   = trigger_delay;
          runs_d  = (num_runs == '0) ? RUN_WIDTH'(1) : num_runs;
          gap_d   = run_gap;
          done_d  = 1'b0;
          terr_d  = 1'b0;
          rc_d    = '0;
          state_d = ARM;
        end
        ARM: begin
          cnt_d   = dly_q;
          state_d = DELAY;
        end
        DELAY: begin
          if (cnt == '0) state_d = FIRE;
          else           cnt_d   = cnt - 1'b1;
        end
        FIRE: begin
          wdog_d  = '0;
          state_d = WAIT_LOW;
        end
        WAIT_LOW: begin
          if (wdog == WD_MAX) begin
            terr_d  = 1'b1;
            state_d = WAIT_CAP;
          end else begin
            wdog_d = wdog + 1'b1;
            if (!rsa_ready) state_d = WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          // A completion seen on the last watchdog cycle still counts as a run.
          if (rsa_ready) begin
            if (run_count < runs_q) rc_d = rc_inc[RUN_WIDTH-1:0];
            if (rc_inc >= {1'b0, runs_q}) begin
              state_d = WAIT_CAP;
            end else begin
              gcnt_d  = gap_q;
              state_d = GAP;
            end
          end else if (wdog == WD_MAX) begin
            terr_d  = 1'b1;
            state_d = WAIT_CAP;
          end else begin
            wdog_d = wdog + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == '0) state_d = FIRE;
          else            gcnt_d  = gcnt - 1'b1;
        end
        WAIT_CAP: if (capture_done) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Datapath and registered outputs; pulses decode the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q       <= '0;
      runs_q      <= '0;
      gap_q       <= '0;
      cnt         <= '0;
      gcnt        <= '0;
      wdog        <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      run_count   <= '0;
      ro_go       <= 1'b0;
      rsa_go      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      runs_q      <= runs_d;
      gap_q       <= gap_d;
      cnt         <= cnt_d;
      gcnt        <= gcnt_d;
      wdog        <= wdog_d;
      done        <= done_d;
      timeout_err <= terr_d;
      run_count   <= rc_d;
      ro_go       <= (state_d == ARM);
      rsa_go      <= (state_d == FIRE);
      busy        <= !((state_d == IDLE) || (state_d == DONE));
    end
  end

endmodule

// File: tb/tb_spa_trigger_ctrl.sv
// Bench for spa_trigger_ctrl: a table of capture scenarios plus hand-written
// abort/reset sequences. Expected ro_go/rsa_go cycles are pushed to queues
// when the stimulus that causes them is driven and popped by a monitor.
module tb_spa_trigger_ctrl;
  localparam int CW = 65, RW = 16, TO = 64;

  logic          clk = 1'b0, rst, go, abort, rsa_ready, capture_done;
  logic [CW-1:0] trigger_delay;
  logic [RW-1:0] num_runs, run_gap, run_count;
  logic          ro_go, rsa_go, busy, done, timeout_err;

  int cyc = 0, n_vec = 0, n_err = 0;
  int exp_ro[$], exp_rsa[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spa_trigger_ctrl #(.CNT_WIDTH(CW), .RUN_WIDTH(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort),
    .trigger_delay(trigger_delay), .num_runs(num_runs), .run_gap(run_gap),
    .rsa_ready(rsa_ready), .capture_done(capture_done),
    .ro_go(ro_go), .rsa_go(rsa_go), .busy(busy), .done(done),
    .timeout_err(timeout_err), .run_count(run_count)
  );

  typedef struct {
    int dly; int runs; int gap; int lat; bit hang; bit early_cap;
    int exp_pulses; int exp_rc; bit exp_terr;
  } vec_t;
  vec_t vecs[7];

  task automatic check(string nm, longint act, longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: every pulse must match the head of its expectation queue.
  always @(negedge clk) if (rst !== 1'b1) begin
    if (ro_go === 1'b1) begin
      check("ro_go_expected", exp_ro.size() > 0, 1);
      if (exp_ro.size() > 0) check("ro_go_cycle", cyc, exp_ro.pop_front());
    end
    if (rsa_go === 1'b1) begin
      check("rsa_go_expected", exp_rsa.size() > 0, 1);
      if (exp_rsa.size() > 0) check("rsa_go_cycle", cyc, exp_rsa.pop_front());
    end
  end

  task automatic wait_rsa(output bit seen);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (rsa_go === 1'b1) seen = 1;
    end
    check("rsa_go_seen", seen, 1);
  endtask

  task automatic start(int dly, int runs, int gap, output int t);
    @(negedge clk);
    trigger_delay = CW'(dly); num_runs = RW'(runs); run_gap = RW'(gap);
    go = 1; t = cyc + 1;
    exp_ro.push_back(t);
    exp_rsa.push_back(t + 2 + dly);
    @(negedge clk);
    go = 0;
  endtask

  task automatic run_capture(vec_t v);
    int t, f, r, c; bit seen;
    start(v.dly, v.runs, v.gap, t);
    check("busy_after_go", busy, 1);
    check("done_cleared", done, 0);
    check("terr_cleared", timeout_err, 0);
    check("rc_cleared", run_count, 0);
    if (v.early_cap) capture_done = 1;
    for (int k = 0; k < v.exp_pulses; k++) begin
      wait_rsa(seen);
      if (!seen) return;
      f = cyc;
      if (v.early_cap && k == 0) begin
        capture_done = 0;
        check("early_cap_ignored", done, 0);
      end
      @(negedge clk);
      rsa_ready = 0;
      if (v.hang) begin
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          if (timeout_err === 1'b1) seen = 1;
        end
        check("timeout_cycle", seen ? cyc : -1, f + TO + 1);
        rsa_ready = 1;
      end else begin
        repeat (v.lat) @(negedge clk);
        rsa_ready = 1;
        r = cyc + 1;
        if (k < v.exp_pulses - 1) exp_rsa.push_back(r + 1 + v.gap);
      end
    end
    repeat (3) @(negedge clk);
    check("wait_cap_busy", busy, 1);
    check("wait_cap_done", done, 0);
    capture_done = 1;
    c = cyc + 1;
    @(negedge clk);
    capture_done = 0;
    check("done_cycle", cyc, c);
    check("done_set", done, 1);
    check("busy_clear", busy, 0);
    check("run_count", run_count, v.exp_rc);
    check("timeout_err", timeout_err, v.exp_terr);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t, f, r; bit seen;
    vecs[0] = '{dly:5, runs:1, gap:0, lat:40, hang:0, early_cap:0, exp_pulses:1, exp_rc:1, exp_terr:0};
    vecs[1] = '{dly:0, runs:3, gap:4, lat:40, hang:0, early_cap:0, exp_pulses:3, exp_rc:3, exp_terr:0};
    vecs[2] = '{dly:3, runs:0, gap:2, lat:10, hang:0, early_cap:0, exp_pulses:1, exp_rc:1, exp_terr:0};
    vecs[3] = '{dly:2, runs:2, gap:0, lat:3,  hang:0, early_cap:1, exp_pulses:2, exp_rc:2, exp_terr:0};
    vecs[4] = '{dly:1, runs:2, gap:1, lat:1,  hang:0, early_cap:0, exp_pulses:2, exp_rc:2, exp_terr:0};
    vecs[5] = '{dly:2, runs:3, gap:1, lat:0,  hang:1, early_cap:0, exp_pulses:1, exp_rc:0, exp_terr:1};
    vecs[6] = '{dly:4, runs:1, gap:0, lat:5,  hang:0, early_cap:0, exp_pulses:1, exp_rc:1, exp_terr:0};

    rst = 1; go = 0; abort = 0; rsa_ready = 1; capture_done = 0;
    trigger_delay = '0; num_runs = '0; run_gap = '0;
    repeat (2) @(negedge clk);
    check("rst_ro_go", ro_go, 0);
    check("rst_rsa_go", rsa_go, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_run_count", run_count, 0);
    rst = 0;

    foreach (vecs[i]) run_capture(vecs[i]);

    // Abort in DELAY; a go while busy must not restart the sequence.
    start(20, 1, 0, t);
    void'(exp_rsa.pop_back());
    go = 1;
    @(negedge clk);
    go = 0; abort = 1;
    @(negedge clk);
    abort = 0;
    check("abortA_busy", busy, 0);
    check("abortA_done", done, 0);
    repeat (30) @(negedge clk);
    check("abortA_idle", busy, 0);

    // Abort in WAIT_HIGH together with go: abort wins, no new capture starts.
    start(0, 2, 0, t);
    wait_rsa(seen);
    @(negedge clk);
    rsa_ready = 0;
    repeat (4) @(negedge clk);
    check("abortB_in_wait", busy, 1);
    go = 1; abort = 1;
    @(negedge clk);
    go = 0; abort = 0;
    check("abortB_busy", busy, 0);
    check("abortB_done", done, 0);
    check("abortB_rc", run_count, 0);
    rsa_ready = 1;
    repeat (20) @(negedge clk);
    check("abortB_idle", busy, 0);

    // Reset while in GAP after two completed runs.
    start(0, 4, 30, t);
    for (int k = 0; k < 2; k++) begin
      wait_rsa(seen);
      @(negedge clk);
      rsa_ready = 0;
      repeat (5) @(negedge clk);
      rsa_ready = 1;
      r = cyc + 1;
      exp_rsa.push_back(r + 1 + 30);
    end
    @(negedge clk);
    check("gap_rc", run_count, 2);
    check("gap_busy", busy, 1);
    rst = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rc", run_count, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ro_go", ro_go, 0);
    check("mid_rst_rsa_go", rsa_go, 0);
    exp_rsa.delete();
    @(negedge clk);
    rst = 0;
    run_capture(vecs[1]);

    repeat (5) @(negedge clk);
    check("ro_queue_empty", exp_ro.size(), 0);
    check("rsa_queue_empty", exp_rsa.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spa_trigger_ctrl.md
# spa_trigger_ctrl

Sequencer that coordinates one side-channel capture: starts the ring-oscillator sampling pipeline, waits a programmable pre-trigger delay, then fires the RSA modular-exponentiation core one or more times and waits for the DMA write-back to finish. It sits in the AFU between the MMIO registers (go/config/status) and the `ro_top`, `RSACypher` and DMA write channel. Every trace therefore has a deterministic, cycle-accurate offset between sensor start and victim start.

## Interface
- `CNT_WIDTH`, default 65: width of `num_samples` and `trigger_delay`.
- `RUN_WIDTH`, default 16: width of `num_runs`, `run_gap` and `run_count`.
- `TIMEOUT`, default 2**24: maximum cycles to wait for any single RSA operation.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `go` in 1: single-cycle start pulse from MMIO.
- `abort` in 1: single-cycle abort pulse from MMIO.
- `trigger_delay` in CNT_WIDTH: cycles between `ro_go` and the first `rsa_go`.
- `num_runs` in RUN_WIDTH: RSA operations per capture; 0 is treated as 1.
- `run_gap` in RUN_WIDTH: idle cycles between one `rsa_ready` and the next `rsa_go`.
- `rsa_ready` in 1: RSA core idle/result-valid level.
- `capture_done` in 1: DMA write-done level (`dma.wr_done`).
- `ro_go` out 1: one-cycle start pulse to `ro_top`.
- `rsa_go` out 1: one-cycle `ds` pulse to the RSA core.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: sticky completion flag, cleared by the next accepted `go`.
- `timeout_err` out 1: sticky; set when an RSA run exceeds TIMEOUT, cleared by the next accepted `go`.
- `run_count` out RUN_WIDTH: number of completed RSA runs in the current capture.

## Operation
- States: IDLE, ARM, DELAY, FIRE, WAIT_LOW, WAIT_HIGH, GAP, WAIT_CAP, DONE.
- IDLE/DONE + `go`:
  - latch `trigger_delay`, `num_runs` (0→1) and `run_gap` into internal registers;
  - clear `done`, `timeout_err` and `run_count`;
  - go to ARM.
- `go` in any other state is ignored.
- ARM: assert `ro_go` for 1 cycle; load delay counter with the latched `trigger_delay`; go to DELAY.
- DELAY: decrement counter each cycle; when counter = 0, go to FIRE. A delay of 0 spends exactly one cycle in DELAY.
- FIRE: assert `rsa_go` for 1 cycle; clear watchdog; go to WAIT_LOW.
- WAIT_LOW: wait for `rsa_ready`=0 (core accepted the start), then go to WAIT_HIGH.
- WAIT_HIGH: wait for `rsa_ready`=1. On that edge:
  - `run_count`++;
  - if `run_count`+1 = latched runs, go to WAIT_CAP;
  - else load gap counter with `run_gap` and go to GAP.
- Watchdog: counts every cycle in WAIT_LOW/WAIT_HIGH. When it reaches TIMEOUT−1, set `timeout_err` and go to WAIT_CAP. Remaining runs are skipped.
- GAP: decrement the gap counter; at 0, go to FIRE. A gap of 0 spends exactly one cycle in GAP.
- WAIT_CAP: wait for `capture_done`=1, then set `done` and go to DONE.
- DONE behaves like IDLE, except `done` stays high.
- `abort` in any busy state:
  - next state is IDLE;
  - `done` is not set, `run_count` holds its value;
  - no pulse is emitted in the abort cycle;
  - `abort` wins over a simultaneous `go`.
- Counters saturate, never wrap. `run_count` cannot exceed the latched runs value.

## Timing
- Reset values: state IDLE; `ro_go`=0, `rsa_go`=0, `busy`=0, `done`=0, `timeout_err`=0, `run_count`=0; internal counters 0.
- All outputs are registered; no combinational input→output paths.
- `go` sampled at edge t:
  - `ro_go` high during cycle t+1;
  - first `rsa_go` high during cycle t+3+`trigger_delay`;
  - `busy` high from t+1.
- `rsa_ready` rising sampled at edge r: the next `rsa_go` occurs at r+2+`run_gap` (GAP entry at r+1, `run_gap`+1 cycles in GAP).
- `capture_done` sampled at edge c: `done`=1 and `busy`=0 from c+1.
- `capture_done` high before WAIT_CAP is not latched early; it is a level sampled only in WAIT_CAP.
- Reset mid-operation: all outputs return to reset values asynchronously; a pulse in flight is truncated.

## Test plan
- Reset then `go` with `trigger_delay`=5, runs=1, `rsa_ready` model (low 1 cycle after ds, high 40 cycles later) → `ro_go` at t+1, `rsa_go` at t+8, `run_count`=1, `done` one cycle after `capture_done`.
- `trigger_delay`=0, runs=3, `run_gap`=4 → `rsa_go` at t+3; successive `rsa_go` pulses exactly 6 cycles after each `rsa_ready` rise; `run_count`=3; exactly 3 `rsa_go` pulses total.
- runs=0 → behaves exactly as runs=1 (single `rsa_go`, `run_count`=1).
- TIMEOUT=64, `rsa_ready` held low forever → `timeout_err`=1 after 64 cycles in WAIT_LOW/WAIT_HIGH; then `done`=1 after `capture_done`; second `go` clears both flags.
- `abort` asserted in DELAY, and separately in WAIT_HIGH with simultaneous `go` → IDLE next cycle, no `rsa_go`, `done`=0, `busy`=0; `go` during busy produces no second `ro_go`.
- Assert `rst` in GAP with `run_count`=2 → all outputs 0 immediately; subsequent `go` runs a full capture normally.
